// File: rtl/delayed_write_ctrl_if.sv
// Request/response bundle for the cancellable delayed-write controller.
// The master drives the request and abort; the slave returns status and the committed value.
interface delayed_write_ctrl_if #(
  parameter int DW = 4,
  parameter int CW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_data;
  logic [CW-1:0] req_delay;
  logic          abort;
  logic [DW-1:0] value;
  logic          busy;
  logic [CW-1:0] remaining;
  logic          done;
  logic          cancelled;

  modport master (
    output req_valid, req_data, req_delay, abort,
    input  req_ready, value, busy, remaining, done, cancelled
  );

  modport slave (
    input  req_valid, req_data, req_delay, abort,
    output req_ready, value, busy, remaining, done, cancelled
  );
endinterface

// File: rtl/delayed_write_ctrl.sv
// Cancellable delayed register write: a (data, delay) request is committed to
// value after delay cycles unless abort arrives first.
module delayed_write_ctrl #(
  parameter int            DW        = 4,
  parameter int            CW        = 4,
  parameter logic [DW-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  delayed_write_ctrl_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] value_reg, value_next;
  logic [DW-1:0] data_reg, data_next;
  logic [CW-1:0] remaining_reg, remaining_next;
  logic          done_reg, done_next;
  logic          cancelled_reg, cancelled_next;
  logic          accept;

  // Abort holds off new requests combinationally, even while idle.
  assign bus.req_ready = (state_reg == IDLE) && !bus.abort;
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      value_reg     <= RESET_VAL;
      data_reg      <= '0;
      remaining_reg <= '0;
      done_reg      <= 1'b0;
      cancelled_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      value_reg     <= value_next;
      data_reg      <= data_next;
      remaining_reg <= remaining_next;
      done_reg      <= done_next;
      cancelled_reg <= cancelled_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    value_next     = value_reg;
    data_next      = data_reg;
    remaining_next = remaining_reg;
    done_next      = 1'b0;
    cancelled_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (bus.req_delay == '0) begin
            value_next = bus.req_data;
            done_next  = 1'b1;
          end else begin
            data_next      = bus.req_data;
            remaining_next = bus.req_delay - CW'(1);
            state_next     = WAIT;
          end
        end
      end
      WAIT: begin
        // Abort takes priority over a commit landing on the same edge.
        if (bus.abort) begin
          cancelled_next = 1'b1;
          remaining_next = '0;
          state_next     = IDLE;
        end else if (remaining_reg == '0) begin
          value_next = data_reg;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          remaining_next = remaining_reg - CW'(1);
        end
      end
      default: begin
        state_next     = IDLE;
        remaining_next = '0;
      end
    endcase
  end

  assign bus.value     = value_reg;
  assign bus.busy      = (state_reg == WAIT);
  assign bus.remaining = remaining_reg;
  assign bus.done      = done_reg;
  assign bus.cancelled = cancelled_reg;

endmodule
